// File: rtl/vote_report_pkg.sv
// Shared constants, state encodings and the tally-to-ASCII helper for the vote report transmitter.
package vote_report_pkg;

  localparam int MSG_LEN = 20;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_2  = 8'h32;
  localparam logic [7:0] ASCII_3  = 8'h33;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_C1   = 2'd1,
    WIN_C2   = 2'd2,
    WIN_C3   = 2'd3
  } winner_t;

  typedef enum logic [2:0] {
    MSG_IDLE,
    MSG_LOAD,
    MSG_SEND,
    MSG_WAIT,
    MSG_FIN
  } msg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Two ASCII digits {tens, ones}; anything above 99 is shown as "99".
  function automatic logic [15:0] tally_to_ascii(input logic [7:0] tally);
    logic [7:0] sat;
    logic [7:0] tens;
    logic [7:0] ones;
    sat  = (tally > 8'd99) ? 8'd99 : tally;
    tens = sat / 8'd10;
    ones = sat - (tens * 8'd10);
    return {ASCII_0 + tens, ASCII_0 + ones};
  endfunction

endpackage

// File: rtl/vote_report_tx_uart_tx_byte.sv
// 8N1 byte serializer; accepts the next byte in the last stop-bit cycle so bytes run back-to-back.
module uart_tx_byte
  import vote_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             bit_end;

  assign bit_end = (baud_cnt_reg == CNT_LAST);
  assign ready   = (state_reg == TX_IDLE) || ((state_reg == TX_STOP) && bit_end);

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_reg    <= TX_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx           <= 1'b1;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          if (valid) begin
            shift_reg    <= data;
            tx           <= 1'b0;
            baud_cnt_reg <= '0;
            state_reg    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx           <= shift_reg[0];
            shift_reg    <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
            state_reg    <= TX_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              tx        <= 1'b1;
              state_reg <= TX_STOP;
            end else begin
              tx          <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            // A byte waiting here starts its start bit on the very next cycle.
            if (valid) begin
              shift_reg <= data;
              tx        <= 1'b0;
              state_reg <= TX_START;
            end else begin
              state_reg <= TX_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vote_report_tx.sv
// Snapshots the poll result on start and sends "1=dd 2=dd 3=dd W=w\r\n" over the UART.
module vote_report_tx
  import vote_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tally_1,
  input  logic [7:0] tally_2,
  input  logic [7:0] tally_3,
  input  logic [1:0] winner,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

  msg_state_t  state_reg;
  logic [4:0]  idx_reg;
  logic [7:0]  snap_1_reg;
  logic [7:0]  snap_2_reg;
  logic [7:0]  snap_3_reg;
  winner_t     snap_w_reg;
  logic [15:0] dig_1_reg;
  logic [15:0] dig_2_reg;
  logic [15:0] dig_3_reg;
  logic [7:0]  win_char_reg;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;

  assign byte_valid = (state_reg == MSG_SEND);

  always_comb begin
    byte_data = ASCII_SP;
    case (idx_reg)
      5'd0:    byte_data = ASCII_1;
      5'd1:    byte_data = ASCII_EQ;
      5'd2:    byte_data = dig_1_reg[15:8];
      5'd3:    byte_data = dig_1_reg[7:0];
      5'd5:    byte_data = ASCII_2;
      5'd6:    byte_data = ASCII_EQ;
      5'd7:    byte_data = dig_2_reg[15:8];
      5'd8:    byte_data = dig_2_reg[7:0];
      5'd10:   byte_data = ASCII_3;
      5'd11:   byte_data = ASCII_EQ;
      5'd12:   byte_data = dig_3_reg[15:8];
      5'd13:   byte_data = dig_3_reg[7:0];
      5'd15:   byte_data = ASCII_W;
      5'd16:   byte_data = ASCII_EQ;
      5'd17:   byte_data = win_char_reg;
      5'd18:   byte_data = ASCII_CR;
      5'd19:   byte_data = ASCII_LF;
      default: byte_data = ASCII_SP;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_reg    <= MSG_IDLE;
      idx_reg      <= '0;
      snap_1_reg   <= '0;
      snap_2_reg   <= '0;
      snap_3_reg   <= '0;
      snap_w_reg   <= WIN_NONE;
      dig_1_reg    <= '0;
      dig_2_reg    <= '0;
      dig_3_reg    <= '0;
      win_char_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_reg)
        MSG_IDLE: begin
          if (start) begin
            snap_1_reg <= tally_1;
            snap_2_reg <= tally_2;
            snap_3_reg <= tally_3;
            snap_w_reg <= winner_t'(winner);
            busy       <= 1'b1;
            state_reg  <= MSG_LOAD;
          end
        end
        MSG_LOAD: begin
          dig_1_reg    <= tally_to_ascii(snap_1_reg);
          dig_2_reg    <= tally_to_ascii(snap_2_reg);
          dig_3_reg    <= tally_to_ascii(snap_3_reg);
          win_char_reg <= ASCII_0 + {6'd0, snap_w_reg};
          idx_reg      <= '0;
          state_reg    <= MSG_SEND;
        end
        MSG_SEND: begin
          if (byte_ready) state_reg <= MSG_WAIT;
        end
        MSG_WAIT: begin
          // Next byte is queued while the current one shifts out; only the last byte waits for its stop bit.
          if (idx_reg != LAST_IDX) begin
            idx_reg   <= idx_reg + 5'd1;
            state_reg <= MSG_SEND;
          end else if (byte_ready) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= MSG_FIN;
          end
        end
        MSG_FIN: begin
          done      <= 1'b0;
          idx_reg   <= '0;
          state_reg <= MSG_IDLE;
        end
        default: state_reg <= MSG_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .data      (byte_data),
    .valid     (byte_valid),
    .ready     (byte_ready),
    .tx        (tx)
  );

endmodule
